// File: rtl/spi_responder_if.sv
// Bus bundle for spi_responder: SPI pins plus the byte-wide transmit/receive handshake.
// The responder uses the slave modport; the SPI master / host side uses the master modport.
interface spi_responder_if;
    logic       SPI_CLK;
    logic       SPI_CS;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic       SPI_MISO_OE;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;
    logic [7:0] RxData;
    logic       RxValid;
    logic       TxUnderrun;

    modport slave (
        input  SPI_CLK, SPI_CS, SPI_MOSI, TxData, TxValid,
        output SPI_MISO, SPI_MISO_OE, TxReady, RxData, RxValid, TxUnderrun
    );

    modport master (
        output SPI_CLK, SPI_CS, SPI_MOSI, TxData, TxValid,
        input  SPI_MISO, SPI_MISO_OE, TxReady, RxData, RxValid, TxUnderrun
    );
endinterface

// File: rtl/spi_responder.sv
// SPI mode-0 responder oversampled by MasterCLK: synchronizes the SPI pins, shifts bytes in/out,
// and offers a one-entry transmit buffer with an underrun pulse when nothing is buffered.
module spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic MasterCLK,
    input  logic Reset_n,
    spi_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_dly_q;
    logic                   cs_dly_q;

    state_t     state_q,    state_d;
    logic [2:0] cnt_q,      cnt_d;
    logic [7:0] rxshift_q,  rxshift_d;
    logic [7:0] txshift_q,  txshift_d;
    logic [7:0] rxdata_q,   rxdata_d;
    logic [7:0] txbuf_q,    txbuf_d;
    logic       txfull_q,   txfull_d;
    logic       rxvalid_q,  rxvalid_d;
    logic       underrun_q, underrun_d;
    logic       load;

    logic sclk, cs, mosi;
    logic sclk_rise, sclk_fall, cs_fall;

    assign sclk      = sclk_sync_q[SYNC_STAGES-1];
    assign cs        = cs_sync_q[SYNC_STAGES-1];
    assign mosi      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk & ~sclk_dly_q;
    assign sclk_fall = ~sclk & sclk_dly_q;
    assign cs_fall   = ~cs & cs_dly_q;

    always_ff @(posedge MasterCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            rxshift_q   <= 8'h00;
            txshift_q   <= 8'hFF;
            rxdata_q    <= 8'h00;
            txbuf_q     <= 8'h00;
            txfull_q    <= 1'b0;
            rxvalid_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SPI_CLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.SPI_CS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.SPI_MOSI};
            sclk_dly_q  <= sclk;
            cs_dly_q    <= cs;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rxshift_q   <= rxshift_d;
            txshift_q   <= txshift_d;
            rxdata_q    <= rxdata_d;
            txbuf_q     <= txbuf_d;
            txfull_q    <= txfull_d;
            rxvalid_q   <= rxvalid_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rxshift_d  = rxshift_q;
        txshift_d  = txshift_q;
        rxdata_d   = rxdata_q;
        txbuf_d    = txbuf_q;
        txfull_d   = txfull_q;
        rxvalid_d  = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;

        // A write never bypasses into the shift register; a same-cycle load still sees the old flag.
        if (bus.TxValid && !txfull_q) begin
            txbuf_d  = bus.TxData;
            txfull_d = 1'b1;
        end

        if (cs) begin
            state_d   = IDLE;
            cnt_d     = 3'd0;
            txshift_d = 8'hFF;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d     = 3'd0;
                    txshift_d = 8'hFF;
                    if (cs_fall) state_d = LOAD;
                end
                LOAD: begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rxshift_d = {rxshift_q[6:0], mosi};
                        cnt_d     = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rxdata_d  = {rxshift_q[6:0], mosi};
                            rxvalid_d = 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (cnt_q != 3'd0) txshift_d = {txshift_q[6:0], 1'b1};
                        else               load      = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (load) begin
            if (txfull_q) begin
                txshift_d = txbuf_q;
                txfull_d  = 1'b0;
            end else begin
                txshift_d  = IDLE_BYTE;
                underrun_d = 1'b1;
            end
        end
    end

    assign bus.SPI_MISO    = cs ? 1'b1 : txshift_q[7];
    assign bus.SPI_MISO_OE = ~cs;
    assign bus.TxReady     = ~txfull_q;
    assign bus.RxData      = rxdata_q;
    assign bus.RxValid     = rxvalid_q;
    assign bus.TxUnderrun  = underrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// Testbench for spi_responder: bit-bangs an SPI mode-0 master against the responder and
// compares bytes, pulses and handshake flags with vector tables and a queue-based buffer model.
module tb_spi_responder;

    localparam int HALF = 6;

    logic MasterCLK = 1'b0;
    logic Reset_n   = 1'b0;

    spi_responder_if bus();

    spi_responder #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .MasterCLK(MasterCLK),
        .Reset_n  (Reset_n),
        .bus      (bus)
    );

    always #5 MasterCLK = ~MasterCLK;

    int errors = 0;
    int checks = 0;

    // Passive monitor: every cycle RxValid is seen high logs a byte, so a stretched pulse shows up.
    logic [7:0] rx_log[$];
    int         und_tot = 0;
    always @(negedge MasterCLK) begin
        if (bus.RxValid)    rx_log.push_back(bus.RxData);
        if (bus.TxUnderrun) und_tot++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge MasterCLK);
        bus.TxData  = d;
        bus.TxValid = 1'b1;
        @(negedge MasterCLK);
        bus.TxValid = 1'b0;
    endtask

    // One CS-low window of nclk clocks; the last falling SPI_CLK coincides with CS rising.
    task automatic xfer(input int nclk, input logic [7:0] m0, input logic [7:0] m1,
                        input bit mid_wr, input logic [7:0] mid_byte,
                        output logic [7:0] s0, output logic [7:0] s1, output bit oe_ok);
        int b;
        int i;
        s0 = 8'h00;
        s1 = 8'h00;
        oe_ok = 1'b1;
        @(negedge MasterCLK);
        bus.SPI_CS = 1'b0;
        repeat (8) @(negedge MasterCLK);
        for (int k = 0; k < nclk; k++) begin
            b = k / 8;
            i = 7 - (k % 8);
            bus.SPI_MOSI = (b == 0) ? m0[i] : m1[i];
            repeat (HALF) @(negedge MasterCLK);
            bus.SPI_CLK = 1'b1;
            if (b == 0) s0[i] = bus.SPI_MISO;
            else        s1[i] = bus.SPI_MISO;
            if (!bus.SPI_MISO_OE) oe_ok = 1'b0;
            repeat (HALF) @(negedge MasterCLK);
            if (k == nclk - 1) bus.SPI_CS = 1'b1;
            bus.SPI_CLK = 1'b0;
            if (mid_wr && k == 2) begin
                bus.TxData  = mid_byte;
                bus.TxValid = 1'b1;
                @(negedge MasterCLK);
                bus.TxValid = 1'b0;
            end
        end
        repeat (8) @(negedge MasterCLK);
    endtask

    typedef struct {
        bit         pre;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_und;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] model_buf[$];
    logic [7:0] s0, s1, e0, e1, m0, m1, md, prev, d;
    bit         ok, mw;
    int         base_rx, base_u, n, eu;

    function automatic int rx_at(input int idx);
        if (idx < rx_log.size()) return int'(rx_log[idx]);
        return -1;
    endfunction

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 1};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
        vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h01, 0};
        vecs[4] = '{1'b0, 8'h00, 8'h96, 8'hFF, 8'h96, 1};

        bus.SPI_CLK  = 1'b0;
        bus.SPI_CS   = 1'b1;
        bus.SPI_MOSI = 1'b0;
        bus.TxData   = 8'h00;
        bus.TxValid  = 1'b0;
        repeat (3) @(negedge MasterCLK);
        check("reset_miso",     int'(bus.SPI_MISO),    1);
        check("reset_oe",       int'(bus.SPI_MISO_OE), 0);
        check("reset_txready",  int'(bus.TxReady),     1);
        check("reset_rxdata",   int'(bus.RxData),      0);
        check("reset_rxvalid",  int'(bus.RxValid),     0);
        check("reset_underrun", int'(bus.TxUnderrun),  0);
        Reset_n = 1'b1;
        repeat (3) @(negedge MasterCLK);

        for (int v = 0; v < 5; v++) begin
            base_rx = rx_log.size();
            base_u  = und_tot;
            if (vecs[v].pre) wr(vecs[v].tx);
            @(negedge MasterCLK);
            check($sformatf("vec%0d_txready_pre", v), int'(bus.TxReady), int'(!vecs[v].pre));
            xfer(8, vecs[v].mosi, 8'h00, 1'b0, 8'h00, s0, s1, ok);
            check($sformatf("vec%0d_miso", v),     int'(s0), int'(vecs[v].exp_miso));
            check($sformatf("vec%0d_oe", v),       int'(ok), 1);
            check($sformatf("vec%0d_rxcount", v),  rx_log.size() - base_rx, 1);
            check($sformatf("vec%0d_rxbyte", v),   rx_at(base_rx), int'(vecs[v].exp_rx));
            check($sformatf("vec%0d_rxdata", v),   int'(bus.RxData), int'(vecs[v].exp_rx));
            check($sformatf("vec%0d_underrun", v), und_tot - base_u, vecs[v].exp_und);
            check($sformatf("vec%0d_txready", v),  int'(bus.TxReady), 1);
            check($sformatf("vec%0d_oe_idle", v),  int'(bus.SPI_MISO_OE), 0);
        end

        // Two bytes back to back, second byte written while the first is shifting.
        base_rx = rx_log.size();
        base_u  = und_tot;
        wr(8'h11);
        xfer(16, 8'h81, 8'h7E, 1'b1, 8'h22, s0, s1, ok);
        check("two_miso0",    int'(s0), 8'h11);
        check("two_miso1",    int'(s1), 8'h22);
        check("two_rxcount",  rx_log.size() - base_rx, 2);
        check("two_rx0",      rx_at(base_rx), 8'h81);
        check("two_rx1",      rx_at(base_rx + 1), 8'h7E);
        check("two_underrun", und_tot - base_u, 0);

        // CS raised after five clocks: partial byte dropped.
        prev    = bus.RxData;
        base_rx = rx_log.size();
        xfer(5, 8'hFF, 8'h00, 1'b0, 8'h00, s0, s1, ok);
        check("abort_rxcount", rx_log.size() - base_rx, 0);
        check("abort_rxdata",  int'(bus.RxData), int'(prev));
        base_rx = rx_log.size();
        xfer(8, 8'h5A, 8'h00, 1'b0, 8'h00, s0, s1, ok);
        check("after_abort_rxcount", rx_log.size() - base_rx, 1);
        check("after_abort_rxdata",  int'(bus.RxData), 8'h5A);

        // Reset in the middle of a transfer with a byte buffered.
        wr(8'h77);
        @(negedge MasterCLK);
        bus.SPI_CS = 1'b0;
        repeat (8) @(negedge MasterCLK);
        for (int k = 0; k < 4; k++) begin
            bus.SPI_MOSI = 1'b1;
            repeat (HALF) @(negedge MasterCLK);
            bus.SPI_CLK = 1'b1;
            repeat (HALF) @(negedge MasterCLK);
            bus.SPI_CLK = 1'b0;
        end
        Reset_n = 1'b0;
        #1;
        check("midrst_miso",     int'(bus.SPI_MISO),    1);
        check("midrst_oe",       int'(bus.SPI_MISO_OE), 0);
        check("midrst_txready",  int'(bus.TxReady),     1);
        check("midrst_rxdata",   int'(bus.RxData),      0);
        check("midrst_rxvalid",  int'(bus.RxValid),     0);
        check("midrst_underrun", int'(bus.TxUnderrun),  0);
        @(negedge MasterCLK);
        bus.SPI_CS = 1'b1;
        repeat (4) @(negedge MasterCLK);
        Reset_n = 1'b1;
        repeat (4) @(negedge MasterCLK);
        base_rx = rx_log.size();
        base_u  = und_tot;
        xfer(8, 8'hC3, 8'h00, 1'b0, 8'h00, s0, s1, ok);
        check("postrst_rxcount",  rx_log.size() - base_rx, 1);
        check("postrst_rxdata",   int'(bus.RxData), 8'hC3);
        check("postrst_miso",     int'(s0), 8'hFF);
        check("postrst_underrun", und_tot - base_u, 1);

        // TxValid held with the buffer full must not overwrite it.
        wr(8'h33);
        bus.TxData  = 8'h99;
        bus.TxValid = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            @(negedge MasterCLK);
            if (bus.TxReady) ok = 1'b0;
        end
        bus.TxValid = 1'b0;
        check("hold_txready_low", int'(ok), 1);
        xfer(8, 8'h00, 8'h00, 1'b0, 8'h00, s0, s1, ok);
        check("hold_miso",    int'(s0), 8'h33);
        check("hold_txready", int'(bus.TxReady), 1);
        base_u = und_tot;
        xfer(8, 8'h00, 8'h00, 1'b0, 8'h00, s0, s1, ok);
        check("hold_empty_miso",     int'(s0), 8'hFF);
        check("hold_empty_underrun", und_tot - base_u, 1);

        // Randomized transfers against a one-entry queue model of the transmit buffer.
        for (int it = 0; it < 24; it++) begin
            n  = int'($urandom_range(1, 2));
            mw = 1'($urandom_range(0, 1));
            m0 = 8'($urandom);
            m1 = 8'($urandom);
            md = 8'($urandom);
            @(negedge MasterCLK);
            check($sformatf("rnd%0d_txready", it), int'(bus.TxReady), int'(model_buf.size() == 0));
            if (model_buf.size() == 0 && $urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                wr(d);
                model_buf.push_back(d);
            end
            eu = 0;
            if (model_buf.size() != 0) e0 = model_buf.pop_front();
            else begin e0 = 8'hFF; eu++; end
            if (mw) model_buf.push_back(md);
            e1 = 8'hFF;
            if (n == 2) begin
                if (model_buf.size() != 0) e1 = model_buf.pop_front();
                else eu++;
            end
            base_rx = rx_log.size();
            base_u  = und_tot;
            xfer(n * 8, m0, m1, mw, md, s0, s1, ok);
            check($sformatf("rnd%0d_miso0", it),    int'(s0), int'(e0));
            if (n == 2) check($sformatf("rnd%0d_miso1", it), int'(s1), int'(e1));
            check($sformatf("rnd%0d_rxcount", it),  rx_log.size() - base_rx, n);
            check($sformatf("rnd%0d_rx0", it),      rx_at(base_rx), int'(m0));
            if (n == 2) check($sformatf("rnd%0d_rx1", it), rx_at(base_rx + 1), int'(m1));
            check($sformatf("rnd%0d_underrun", it), und_tot - base_u, eu);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of MasterCLK flip-flops on each SPI input (legal range 2..3).
REQ-002 Parameter IDLE_BYTE, default 8'hFF, byte shifted out when no transmit byte is buffered.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset: MasterCLK clocks all state, and Reset_n clears it asynchronously.
REQ-004 MasterCLK  input  1  system clock; all outputs change only on its rising edge.
REQ-005 Reset_n  input  1  asynchronous active-low reset.
REQ-006 SPI_CLK  input  1  serial clock from the master, mode 0 (CPOL=0, CPHA=0).
REQ-007 SPI_CS  input  1  chip select from the master, active low.
REQ-008 SPI_MOSI  input  1  serial data from the master, MSB first.
REQ-009 SPI_MISO  output  1  serial data to the master, MSB first.
REQ-010 SPI_MISO_OE  output  1  MISO drive enable; 1 only while the synchronized CS is low.
REQ-011 TxData  input  8  next byte to transmit.
REQ-012 TxValid  input  1  TxData is valid this cycle.
REQ-013 TxReady  output  1  the one-entry transmit buffer is empty.
REQ-014 RxData  output  8  last complete byte received; holds its value until the next byte completes.
REQ-015 RxValid  output  1  one-cycle pulse when RxData updates.
REQ-016 TxUnderrun  output  1  one-cycle pulse when IDLE_BYTE is loaded because the buffer is empty.

Function
REQ-017 SPI_CLK, SPI_CS and SPI_MOSI SHALL each pass through SYNC_STAGES flip-flops; edges are detected by comparing the synchronized value with a one-cycle-delayed copy.
REQ-018 Timing limit: SPI_CLK high and low phases SHALL each be at least SYNC_STAGES+1 MasterCLK periods; behaviour outside this limit is undefined.
REQ-019 States: IDLE (CS high), LOAD (first cycle after CS falls), SHIFT (CS low).
- Any state -> IDLE on synchronized CS high.
- IDLE -> LOAD on synchronized CS falling edge.
- LOAD -> SHIFT after 1 cycle.
REQ-020 In IDLE:
- bit counter = 0
- SPI_MISO_OE = 0
- SPI_MISO = 1
- receive shift register held
REQ-021 In LOAD, the transmit shift register SHALL load:
- the buffer byte, if the buffer is full, and the buffer empties;
- otherwise IDLE_BYTE, with TxUnderrun pulsed.
REQ-022 SPI_MISO SHALL always present bit 7 of the transmit shift register while CS is low.
REQ-023 On a synchronized SPI_CLK rising edge in SHIFT:
- the synchronized MOSI is shifted into rxshift bit 0;
- the 3-bit bit counter increments and wraps 7 -> 0.
REQ-024 When the 8th rising edge of a byte is detected (counter 7 -> 0):
- RxData <= {rxshift[6:0], MOSI} on the next MasterCLK edge;
- RxValid pulses in that same cycle.
- This occurs exactly SYNC_STAGES+1 MasterCLK edges after the pin edge.
REQ-025 On a synchronized SPI_CLK falling edge in SHIFT:
- counter != 0: the transmit shift register shifts left by one, filling with 1;
- counter == 0: the next byte is loaded per REQ-021.
REQ-026 The buffer SHALL be written when TxValid && TxReady.
- A write in the same cycle as a load that finds the buffer empty SHALL NOT bypass into the shift register.
- That load uses IDLE_BYTE, and the written byte stays buffered for the next byte.
REQ-027 TxReady SHALL be 0 from the cycle after a write until the cycle after the buffer is consumed.
REQ-028 RxValid SHALL pulse regardless of whether the previous RxData was read; there is no overrun detection.
REQ-029 CS rising mid-byte:
- the partial receive byte is discarded, with no RxValid;
- the partially sent transmit byte is lost;
- the buffered byte is retained.
REQ-030 SPI_CLK edges while synchronized CS is high SHALL be ignored.

Reset
REQ-031 On Reset_n low, outputs SHALL take these values asynchronously:
- SPI_MISO = 1, SPI_MISO_OE = 0
- TxReady = 1, RxData = 0, RxValid = 0, TxUnderrun = 0
- state = IDLE, counter = 0, transmit buffer empty, synchronizers at 1 for SPI_CS and 0 otherwise
REQ-032 Reset asserted mid-transfer SHALL abort the transfer; after release, the block waits for a new CS falling edge.

Verification
REQ-033 Tx 0xA5 buffered; CS low; master sends 0x3C with 8 clocks.
- MISO bits 1,0,1,0,0,1,0,1
- RxData = 0x3C
- one RxValid pulse
- TxReady = 1 after LOAD
REQ-034 Empty buffer; CS low; 8 clocks with MOSI = 0x00.
- MISO = 0xFF
- TxUnderrun pulses once
- RxData = 0x00
REQ-035 Buffer 0x11; 2-byte transfer; 0x22 written during byte 1.
- MISO = 0x11 then 0x22
- master bytes 0x81, 0x7E appear on RxData in order with two RxValid pulses
REQ-036 CS raised after 5 clocks of 0xFF.
- no RxValid
- RxData unchanged
- next full transfer of 0x5A gives RxData = 0x5A
REQ-037 Reset_n pulsed low after 4 clocks; then a new transfer of 0xC3.
- all outputs at reset values during reset
- RxData = 0xC3 after the new transfer
REQ-038 TxValid held high with 0x99 while the buffer is full.
- no write occurs
- buffer retains the first byte
- TxReady stays 0 until consumed
